// File: rtl/timer_ctrl.sv
// Register block and sequencer for the peripheral down-counter timer.
// Drives the load pulse, detects expiry, handles periodic reload and the irq.
module timer_ctrl #(
  parameter int unsigned LOAD_CYCLES = 1,
  parameter int unsigned WIDTH       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [1:0]       addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] timer_data_o,
  output logic             timer_load_o,
  input  logic [WIDTH-1:0] timer_cuenta_i,
  output logic             irq_o
);

  typedef enum logic [1:0] {IDLE, LOAD_P, RUN} state_t;

  localparam logic [3:0] PLAST = 4'(LOAD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [WIDTH-1:0] load_q;
  logic             periodic_q, irq_en_q, expired_q;
  logic             ctrl_wr, stat_wr, start, stop, exp_set;

  assign ctrl_wr = we_i && (addr_i == 2'd0);
  assign stat_wr = we_i && (addr_i == 2'd3);
  assign stop    = ctrl_wr && wdata_i[3];
  assign start   = ctrl_wr && wdata_i[0] && !wdata_i[3];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Control strobes override the sequencer; STOP beats START.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    exp_set = 1'b0;
    if (stop) begin
      state_d = IDLE;
      pcnt_d  = '0;
    end else if (start) begin
      state_d = LOAD_P;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        LOAD_P: begin
          if (pcnt_q == PLAST) begin
            state_d = RUN;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 4'd1;
          end
        end
        RUN: begin
          if (timer_cuenta_i == '0) begin
            exp_set = 1'b1;
            pcnt_d  = '0;
            // A zero reload value would spin forever, so it ends the sequence.
            state_d = (periodic_q && (load_q != '0)) ? LOAD_P : IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_q     <= '0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      if (we_i && (addr_i == 2'd1)) load_q <= wdata_i;
      if (ctrl_wr) begin
        periodic_q <= wdata_i[1];
        irq_en_q   <= wdata_i[2];
      end
      if (exp_set)                     expired_q <= 1'b1;
      else if (stat_wr && wdata_i[0])  expired_q <= 1'b0;
    end
  end

  assign timer_data_o = load_q;
  assign timer_load_o = (state_q == LOAD_P);
  assign irq_o        = expired_q & irq_en_q;

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      2'd0: rdata_o[2:0] = {irq_en_q, periodic_q, 1'b0};
      2'd1: rdata_o      = load_q;
      2'd2: rdata_o      = timer_cuenta_i;
      2'd3: rdata_o[1:0] = {(state_q != IDLE), expired_q};
      default: ;
    endcase
  end

endmodule
